// File: rtl/alu_uart_interface_pkg.sv
// ---------------------------------------------------------------------------
// alu_uart_interface_pkg
// Shared definitions for the serial front end of the ALU:
//   - state_t : sequencer state encoding (WAIT_A .. WAIT_TX)
//   - OP_*    : ALU operation codes, shared by the ALU and its users
// ---------------------------------------------------------------------------
package alu_uart_interface_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    COMPUTE = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // True while a partially received frame is waiting for its next byte.
  function automatic logic in_frame(input state_t s);
    return (s == WAIT_B) || (s == WAIT_OP);
  endfunction

endpackage

// File: rtl/alu_uart_interface_frame_timeout_counter.sv
// ---------------------------------------------------------------------------
// frame_timeout_counter
// Counts clk cycles while a frame is incomplete and flags expiry.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clear   : synchronous clear (has priority over enable)
//   enable  : count this cycle
//   expired : count has reached TIMEOUT_CYCLES-1 while enabled
// ---------------------------------------------------------------------------
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = enable && (count_reg == LAST);

  // Holding at LAST keeps the counter from wrapping; the owner clears it
  // on the expiry transition anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_uart_interface.sv
// ---------------------------------------------------------------------------
// alu_uart_interface
// Collects operand A, operand B and op code as three UART bytes, drives them
// to the ALU on registers, then sends the ALU result back through uart_tx.
//   clk          : system clock
//   i_rst_n      : asynchronous active-low reset
//   i_rx_data    : received byte, valid with i_rx_done
//   i_rx_done    : one-cycle byte-received strobe
//   i_alu_result : combinational ALU output
//   i_tx_done    : one-cycle byte-sent strobe from uart_tx
//   o_datoA/B    : registered operands to the ALU
//   o_operation  : registered op code to the ALU
//   o_tx_data    : result byte to uart_tx
//   o_tx_start   : one-cycle transmit request
//   o_busy       : computing or transmitting; incoming bytes are dropped
//   o_timeout    : one-cycle strobe when a partial frame is abandoned
// ---------------------------------------------------------------------------
module alu_uart_interface
  import alu_uart_interface_pkg::*;
#(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  state_t state_reg;
  logic   frame_open;
  logic   cnt_clear;
  logic   timeout_expired;

  assign frame_open = in_frame(state_reg);
  // Restart the window on every accepted byte, on expiry, and whenever no
  // partial frame is pending (which covers entering WAIT_A).
  assign cnt_clear  = !frame_open || i_rx_done || timeout_expired;

  frame_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_timeout (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .clear  (cnt_clear),
    .enable (frame_open),
    .expired(timeout_expired)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= WAIT_A;
      o_datoA     <= '0;
      o_datoB     <= '0;
      o_operation <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state_reg)
        WAIT_A: begin
          if (i_rx_done) begin
            o_datoA   <= i_rx_data;
            state_reg <= WAIT_B;
          end
        end
        // A byte arriving on the expiry cycle takes priority over timeout.
        WAIT_B: begin
          if (i_rx_done) begin
            o_datoB   <= i_rx_data;
            state_reg <= WAIT_OP;
          end else if (timeout_expired) begin
            o_timeout <= 1'b1;
            state_reg <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            o_operation <= i_rx_data[NB_OP-1:0];
            o_busy      <= 1'b1;
            state_reg   <= COMPUTE;
          end else if (timeout_expired) begin
            o_timeout <= 1'b1;
            state_reg <= WAIT_A;
          end
        end
        // One cycle for the ALU to settle on the freshly loaded operands.
        COMPUTE: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          state_reg  <= SEND;
        end
        SEND: begin
          state_reg <= WAIT_TX;
        end
        WAIT_TX: begin
          if (i_tx_done) begin
            o_busy    <= 1'b0;
            state_reg <= WAIT_A;
          end
        end
        default: begin
          o_busy    <= 1'b0;
          state_reg <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// ---------------------------------------------------------------------------
// tb_alu_uart_interface
// Directed bench for alu_uart_interface with a behavioural ALU stub and a
// short timeout window (100 cycles).
// ---------------------------------------------------------------------------
module tb_alu_uart_interface;
  import alu_uart_interface_pkg::*;

  logic       clk;
  logic       i_rst_n;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic [7:0] i_alu_result;
  logic       i_tx_done;
  logic [7:0] o_datoA;
  logic [7:0] o_datoB;
  logic [5:0] o_operation;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;
  int n_start;

  alu_uart_interface #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_rx_data   (i_rx_data),
    .i_rx_done   (i_rx_done),
    .i_alu_result(i_alu_result),
    .i_tx_done   (i_tx_done),
    .o_datoA     (o_datoA),
    .o_datoB     (o_datoB),
    .o_operation (o_operation),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU stub driven by the DUT's registered operands.
  always_comb begin
    i_alu_result = 8'h00;
    case (o_operation)
      OP_ADD: i_alu_result = o_datoA + o_datoB;
      OP_SUB: i_alu_result = o_datoA - o_datoB;
      OP_AND: i_alu_result = o_datoA & o_datoB;
      OP_OR:  i_alu_result = o_datoA | o_datoB;
      OP_XOR: i_alu_result = o_datoA ^ o_datoB;
      OP_SRA: i_alu_result = $signed(o_datoA) >>> o_datoB;
      OP_SRL: i_alu_result = o_datoA >> o_datoB;
      OP_NOR: i_alu_result = ~(o_datoA | o_datoB);
      default: i_alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    step();
    i_rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {o_datoA, o_datoB, o_operation, o_tx_data, o_tx_start, o_busy, o_timeout}, 64'd0);
    @(negedge clk) i_rst_n = 1'b1;
    step();
    check("after_release",
          {o_datoA, o_datoB, o_operation, o_tx_data, o_tx_start, o_busy, o_timeout}, 64'd0);

    // Basic ADD: 5 + 3
    send_byte(8'h05);
    check("add_datoA", o_datoA, 8'h05);
    send_byte(8'h03);
    check("add_datoB", o_datoB, 8'h03);
    send_byte(8'h20);                       // op strobe in cycle N, now N+1
    check("add_op", o_operation, OP_ADD);
    check("add_compute_busy_nostart", {o_busy, o_tx_start}, 2'b10);
    step();                                 // N+2
    check("add_tx_start_busy", {o_tx_start, o_busy}, 2'b11);
    check("add_tx_data", o_tx_data, 8'h08);
    step();
    check("add_start_one_cycle", o_tx_start, 1'b0);
    repeat (3) step();
    check("add_wait_tx", {o_busy, o_tx_data}, {1'b1, 8'h08});
    tx_done_pulse();
    check("add_busy_fall", o_busy, 1'b0);
    check("add_regs_hold", {o_datoA, o_datoB, o_operation}, {8'h05, 8'h03, OP_ADD});

    // SUB with upper op bits set: 0x10 - 0x04
    send_byte(8'h10);
    send_byte(8'h04);
    send_byte(8'hE2);
    check("sub_op_masked", o_operation, OP_SUB);
    step();
    check("sub_tx", {o_tx_start, o_tx_data}, {1'b1, 8'h0C});
    step();                                 // now in WAIT_TX

    // Bytes arriving while busy are dropped
    n_start = 0;
    send_byte(8'hAA);
    n_start += int'(o_tx_start);
    send_byte(8'hBB);
    n_start += int'(o_tx_start);
    step();
    n_start += int'(o_tx_start);
    check("drop_regs_unchanged", {o_datoA, o_datoB, o_operation}, {8'h10, 8'h04, OP_SUB});
    check("drop_no_extra_start", n_start, 0);
    check("drop_still_busy", o_busy, 1'b1);
    tx_done_pulse();
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h24);
    step();
    check("and_tx", {o_tx_start, o_tx_data}, {1'b1, 8'h01});
    step();
    tx_done_pulse();

    // Timeout: A then silence
    send_byte(8'h07);                       // strobe cycle N, now N+1
    repeat (99) step();                     // N+100: expiry cycle
    check("to_not_yet", o_timeout, 1'b0);
    step();
    check("to_pulse", o_timeout, 1'b1);
    step();
    check("to_single_pulse", o_timeout, 1'b0);
    check("to_datoA_kept", o_datoA, 8'h07);
    send_byte(8'h09);
    check("to_next_is_A", {o_datoA, o_datoB}, {8'h09, 8'h01});

    // Timeout tie: B lands exactly on the expiry cycle
    repeat (99) step();
    send_byte(8'h11);
    check("tie_B_accepted", o_datoB, 8'h11);
    check("tie_no_timeout", o_timeout, 1'b0);
    step();
    check("tie_no_timeout_later", {o_timeout, o_datoA}, {1'b0, 8'h09});

    // Asynchronous reset in WAIT_OP
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_waitop_outputs",
          {o_datoA, o_datoB, o_operation, o_tx_data, o_tx_start, o_busy, o_timeout}, 64'd0);
    @(negedge clk) i_rst_n = 1'b1;
    n_start = 0;
    repeat (5) begin
      step();
      n_start += int'(o_tx_start);
    end
    check("rst_waitop_no_start", n_start, 0);
    send_byte(8'h20);
    check("rst_first_byte_is_A", {o_datoA, o_operation, o_busy}, {8'h20, 6'h00, 1'b0});
    send_byte(8'h03);
    send_byte(8'h20);
    step();
    check("post_rst_frame_tx", {o_tx_start, o_tx_data}, {1'b1, 8'h23});
    step();
    check("post_rst_wait_tx_busy", o_busy, 1'b1);

    // Asynchronous reset in WAIT_TX
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_waittx_outputs",
          {o_datoA, o_datoB, o_operation, o_tx_data, o_tx_start, o_busy, o_timeout}, 64'd0);
    @(negedge clk) i_rst_n = 1'b1;
    n_start = 0;
    repeat (6) begin
      step();
      n_start += int'(o_tx_start);
    end
    check("rst_waittx_no_start", n_start, 0);
    tx_done_pulse();
    check("tx_done_ignored_idle", {o_busy, o_tx_start, o_datoA}, {1'b0, 1'b0, 8'h00});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Sequencer on the serial side of the ALU. Receives operand A, operand B and the operation code as three bytes from the UART receiver, and holds them on registered outputs that drive the ALU.
- Captures the combinational ALU result and hands it to the UART transmitter with a start/done handshake.
- Sits between uart_rx/uart_tx and alu. It is the host-facing counterpart of the switch/LED front end.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, width of the ALU operation code (taken from the low NB_OP bits of the op byte).
- TIMEOUT_CYCLES, 1_000_000, maximum clk cycles allowed between consecutive frame bytes before the frame is abandoned.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_rx_data  input  NB_DATA  byte from uart_rx, valid while i_rx_done=1.
- i_rx_done  input  1  one-cycle strobe: new byte received.
- i_alu_result  input  NB_DATA  combinational ALU output.
- i_tx_done  input  1  one-cycle strobe from uart_tx: byte fully sent.
- o_datoA  output  NB_DATA  registered operand A to ALU.
- o_datoB  output  NB_DATA  registered operand B to ALU.
- o_operation  output  NB_OP  registered operation code to ALU.
- o_tx_data  output  NB_DATA  result byte to uart_tx, stable from o_tx_start until i_tx_done.
- o_tx_start  output  1  one-cycle strobe requesting transmission.
- o_busy  output  1  high from the cycle after the op byte is accepted until i_tx_done.
- o_timeout  output  1  one-cycle strobe when a partial frame is abandoned.

Behaviour:
- Reset (async assert, sync to clk on release):
  - State is WAIT_A.
  - o_datoA, o_datoB, o_operation and o_tx_data are 0.
  - o_tx_start, o_busy and o_timeout are 0.
  - The timeout counter is 0.
- Reset mid-frame or mid-transmission discards everything; no o_tx_start follows.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_datoA <= i_rx_data, go to WAIT_B.
- WAIT_B: on i_rx_done, o_datoB <= i_rx_data, go to WAIT_OP.
- WAIT_OP: on i_rx_done, o_operation <= i_rx_data[NB_OP-1:0] (upper bits ignored), go to COMPUTE.
- COMPUTE: exactly one cycle so the ALU output settles on the new registers. Then o_tx_data <= i_alu_result and go to SEND.
- SEND: o_tx_start=1 for exactly this one cycle, go to WAIT_TX.
- WAIT_TX: on i_tx_done go to WAIT_A.
- o_busy=1 in COMPUTE, SEND and WAIT_TX.
- Latency: op byte strobe in cycle N gives o_tx_start high in cycle N+2.
- Operand/op registers hold their values after transmission until overwritten by the next frame, so the ALU output stays observable.
- i_rx_done while o_busy=1: the byte is dropped, and registers and state are unaffected.
- i_tx_done outside WAIT_TX is ignored.
- Timeout:
  - The counter runs only in WAIT_B and WAIT_OP.
  - It clears on every accepted byte and on entering WAIT_A.
  - When the count reaches TIMEOUT_CYCLES-1 without i_rx_done, the FSM goes to WAIT_A and o_timeout pulses for one cycle.
  - Already-loaded registers keep their values.
  - If i_rx_done coincides with the expiry cycle, the byte wins and no timeout occurs.
- Counter width is clog2(TIMEOUT_CYCLES). No wrap: it saturates by construction at the expiry transition.
- There is no timeout in WAIT_A or WAIT_TX.
- Illegal state encodings return to WAIT_A.

Decomposition:
- Shared package: state encoding localparams (WAIT_A..WAIT_TX), and the ALU op code constants (ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111). The same constants are used by alu and the bench.
- One natural sub-module: frame_timeout_counter (clear/enable/expired), parameterised by TIMEOUT_CYCLES.
- The FSM and registers stay in this module.

Test Plan:
- Basic ADD:
  - Stimulus: after reset, rx bytes 0x05, 0x03, 0x20; ALU stub result = A+B.
  - Response: o_datoA=0x05, o_datoB=0x03, o_operation=6'b100000; o_tx_start one pulse 2 cycles after the op strobe with o_tx_data=0x08; o_busy falls after i_tx_done.
- Upper op bits ignored:
  - Stimulus: op byte 0xE2, A=0x10, B=0x04, stub result = A-B.
  - Response: o_operation=6'b100010; o_tx_data=0x0C.
- Bytes dropped while busy:
  - Stimulus: while in WAIT_TX, send rx bytes 0xAA and 0xBB.
  - Response: o_datoA is unchanged and no extra o_tx_start. The next frame 0x01, 0x01, 0x24 produces o_tx_data = stub(0x01 AND 0x01) = 0x01.
- Timeout with TIMEOUT_CYCLES=100:
  - Stimulus: send A=0x07, then nothing for 100 cycles.
  - Response: o_timeout pulses once; state is WAIT_A. The next byte 0x09 loads o_datoA=0x09, not o_datoB.
- Timeout tie:
  - Stimulus: B arrives exactly on the expiry cycle.
  - Response: it is accepted as B and o_timeout stays 0.
- Reset mid-frame:
  - Stimulus: assert i_rst_n=0 asynchronously in WAIT_OP and in WAIT_TX.
  - Response: all outputs are 0 immediately. After release, no o_tx_start occurs without a full new three-byte frame.
